// File: rtl/box_renderer_pkg.sv
// Shared screen geometry, colours and render-state encoding for the box renderer.
package box_renderer_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int BOX_LOG2 = 4;

  localparam logic [2:0] PLAYER_COLOUR   = 3'b100;
  localparam logic [2:0] OBSTACLE_COLOUR = 3'b001;
  localparam logic [2:0] BG_COLOUR       = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ERASE_P,
    ST_ERASE_O,
    ST_DRAW_P,
    ST_DRAW_O,
    ST_FINISH
  } state_t;

  // Erase phases and the clear sweep paint background; draws use the object colour.
  function automatic logic [2:0] phase_colour(input state_t s);
    case (s)
      ST_DRAW_P: phase_colour = PLAYER_COLOUR;
      ST_DRAW_O: phase_colour = OBSTACLE_COLOUR;
      default:   phase_colour = BG_COLOUR;
    endcase
  endfunction

endpackage

// File: rtl/box_pixel_gen.sv
// Maps a box base position and in-box counter to a screen address plus an on-screen flag.
module box_pixel_gen
  import box_renderer_pkg::*;
(
  input  logic [7:0]            i_base_x,
  input  logic [7:0]            i_base_y,
  input  logic [2*BOX_LOG2-1:0] i_cnt,
  output logic [7:0]            o_x,
  output logic [6:0]            o_y,
  output logic                  o_in_bounds
);

  logic [8:0] w_px;
  logic [8:0] w_py;

  // Nine bits so a box hanging off the right/bottom edge is detected, not wrapped.
  assign w_px = {1'b0, i_base_x} + 9'(i_cnt[BOX_LOG2-1:0]);
  assign w_py = {1'b0, i_base_y} + 9'(i_cnt[2*BOX_LOG2-1:BOX_LOG2]);

  assign o_x         = w_px[7:0];
  assign o_y         = w_py[6:0];
  assign o_in_bounds = (w_px < 9'(SCREEN_W)) && (w_py < 9'(SCREEN_H));

endmodule

// File: rtl/box_renderer.sv
// Erases and redraws the player/obstacle boxes each frame, or clears the screen,
// streaming one registered pixel per clock to the VGA adapter.
module box_renderer
  import box_renderer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       clear_start,
  input  logic [7:0] player_x,
  input  logic [7:0] player_y,
  input  logic [7:0] obstacle_x,
  input  logic [7:0] obstacle_y,
  output logic       busy,
  output logic       done,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);

  state_t     r_state, w_next_state;
  logic [7:0] r_cnt, w_next_cnt;
  logic [7:0] r_cx, w_next_cx;
  logic [6:0] r_cy, w_next_cy;

  logic [7:0] r_new_px, r_new_py, r_new_ox, r_new_oy;
  logic [7:0] r_old_px, r_old_py, r_old_ox, r_old_oy;
  logic       r_old_valid;

  logic       w_accept_frame;
  logic [7:0] w_new_px, w_new_py, w_new_ox, w_new_oy;
  logic [7:0] w_base_x, w_base_y;
  logic [7:0] w_gen_x;
  logic [6:0] w_gen_y;
  logic       w_gen_in;

  logic [7:0] w_nx_x;
  logic [6:0] w_nx_y;
  logic [2:0] w_nx_colour;
  logic       w_nx_plot, w_nx_busy, w_nx_done;

  assign w_accept_frame = (r_state == ST_IDLE) && frame_start && !clear_start;

  // State register plus counters and position latches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_new_px    <= '0;
      r_new_py    <= '0;
      r_new_ox    <= '0;
      r_new_oy    <= '0;
      r_old_px    <= '0;
      r_old_py    <= '0;
      r_old_ox    <= '0;
      r_old_oy    <= '0;
      r_old_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_cx    <= w_next_cx;
      r_cy    <= w_next_cy;
      if (w_accept_frame) begin
        r_new_px <= player_x;
        r_new_py <= player_y;
        r_new_ox <= obstacle_x;
        r_new_oy <= obstacle_y;
      end
      if (w_next_state == ST_FINISH && r_state == ST_DRAW_O) begin
        r_old_px    <= r_new_px;
        r_old_py    <= r_new_py;
        r_old_ox    <= r_new_ox;
        r_old_oy    <= r_new_oy;
        r_old_valid <= 1'b1;
      end else if (w_next_state == ST_FINISH && r_state == ST_CLEAR) begin
        r_old_valid <= 1'b0;
      end
    end
  end

  // Next state: r_state/r_cnt describe the pixel currently on the outputs.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_cx    = r_cx;
    w_next_cy    = r_cy;
    case (r_state)
      ST_IDLE: begin
        w_next_cnt = '0;
        w_next_cx  = '0;
        w_next_cy  = '0;
        if (clear_start)      w_next_state = ST_CLEAR;
        else if (frame_start) w_next_state = r_old_valid ? ST_ERASE_P : ST_DRAW_P;
      end
      ST_CLEAR: begin
        if (r_cx == 8'(SCREEN_W - 1)) begin
          w_next_cx = '0;
          if (r_cy == 7'(SCREEN_H - 1)) begin
            w_next_cy    = '0;
            w_next_state = ST_FINISH;
          end else begin
            w_next_cy = r_cy + 7'd1;
          end
        end else begin
          w_next_cx = r_cx + 8'd1;
        end
      end
      ST_ERASE_P, ST_ERASE_O, ST_DRAW_P, ST_DRAW_O: begin
        w_next_cnt = r_cnt + 8'd1;
        if (r_cnt == 8'hFF) begin
          case (r_state)
            ST_ERASE_P: w_next_state = ST_ERASE_O;
            ST_ERASE_O: w_next_state = ST_DRAW_P;
            ST_DRAW_P:  w_next_state = ST_DRAW_O;
            default:    w_next_state = ST_FINISH;
          endcase
        end
      end
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // On the accept edge the new positions are not latched yet, so take them from the inputs.
  assign w_new_px = (r_state == ST_IDLE) ? player_x   : r_new_px;
  assign w_new_py = (r_state == ST_IDLE) ? player_y   : r_new_py;
  assign w_new_ox = (r_state == ST_IDLE) ? obstacle_x : r_new_ox;
  assign w_new_oy = (r_state == ST_IDLE) ? obstacle_y : r_new_oy;

  always_comb begin
    case (w_next_state)
      ST_ERASE_P: begin w_base_x = r_old_px; w_base_y = r_old_py; end
      ST_ERASE_O: begin w_base_x = r_old_ox; w_base_y = r_old_oy; end
      ST_DRAW_P:  begin w_base_x = w_new_px; w_base_y = w_new_py; end
      default:    begin w_base_x = w_new_ox; w_base_y = w_new_oy; end
    endcase
  end

  box_pixel_gen u_pixel_gen (
    .i_base_x    (w_base_x),
    .i_base_y    (w_base_y),
    .i_cnt       (w_next_cnt),
    .o_x         (w_gen_x),
    .o_y         (w_gen_y),
    .o_in_bounds (w_gen_in)
  );

  // Output decode for the pixel that will be shown after the next edge.
  always_comb begin
    w_nx_x      = '0;
    w_nx_y      = '0;
    w_nx_colour = BG_COLOUR;
    w_nx_plot   = 1'b0;
    w_nx_busy   = 1'b0;
    w_nx_done   = 1'b0;
    case (w_next_state)
      ST_CLEAR: begin
        w_nx_x    = w_next_cx;
        w_nx_y    = w_next_cy;
        w_nx_plot = 1'b1;
        w_nx_busy = 1'b1;
      end
      ST_ERASE_P, ST_ERASE_O, ST_DRAW_P, ST_DRAW_O: begin
        w_nx_x      = w_gen_x;
        w_nx_y      = w_gen_y;
        w_nx_colour = phase_colour(w_next_state);
        w_nx_plot   = w_gen_in;
        w_nx_busy   = 1'b1;
      end
      ST_FINISH: w_nx_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      x      <= w_nx_x;
      y      <= w_nx_y;
      colour <= w_nx_colour;
      plot   <= w_nx_plot;
      busy   <= w_nx_busy;
      done   <= w_nx_done;
    end
  end

endmodule

// File: tb/tb_box_renderer.sv
// Directed plus randomized frames and clears for box_renderer, checked cycle by cycle
// against a pixel-list reference model.
module tb_box_renderer;

  logic       clock = 1'b0;
  logic       reset;
  logic       frame_start, clear_start;
  logic [7:0] player_x, player_y, obstacle_x, obstacle_y;
  logic       busy, done, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  box_renderer dut (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .clear_start (clear_start),
    .player_x    (player_x),
    .player_y    (player_y),
    .obstacle_x  (obstacle_x),
    .obstacle_y  (obstacle_y),
    .busy        (busy),
    .done        (done),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   m_old[4];
  logic m_valid;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_done  = 0;

  always @(negedge clock) if (done === 1'b1) n_done++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: a box is 16 rows of 16 pixels scanned row by row; off-screen pixels are not plotted.
  task automatic add_box(input int bx, input int by, input logic [2:0] c);
    pix_t e;
    int   ax, ay;
    for (int r = 0; r < 16; r++) begin
      for (int col = 0; col < 16; col++) begin
        ax     = bx + col;
        ay     = by + r;
        e.plot = (ax < 160) && (ay < 120);
        e.x    = ax[7:0];
        e.y    = ay[6:0];
        e.c    = c;
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic int visible(input int b, input int lim);
    int v;
    v = lim - b;
    if (v < 0) v = 0;
    if (v > 16) v = 16;
    return v;
  endfunction

  task automatic run_frame(input int px, input int py, input int ox, input int oy, input int pulse_at);
    pix_t e;
    int   seg[4];
    int   nseg, done0;
    exp_q.delete();
    if (m_valid) begin
      add_box(m_old[0], m_old[1], 3'b000);
      add_box(m_old[2], m_old[3], 3'b000);
    end
    add_box(px, py, 3'b100);
    add_box(ox, oy, 3'b001);
    nseg  = exp_q.size() / 256;
    seg   = '{0, 0, 0, 0};
    done0 = n_done;
    @(negedge clock);
    player_x = px[7:0]; player_y = py[7:0]; obstacle_x = ox[7:0]; obstacle_y = oy[7:0];
    frame_start = 1'b1;
    @(posedge clock); #1;
    frame_start = 1'b0;
    player_x = 8'($urandom); player_y = 8'($urandom);
    obstacle_x = 8'($urandom); obstacle_y = 8'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      chk($sformatf("pix%0d", i), 32'({busy, done, plot, x, y, colour}),
          32'({1'b1, 1'b0, e.plot, e.x, e.y, e.c}));
      if (plot === 1'b1) seg[i / 256]++;
      frame_start = (i == pulse_at);
      @(posedge clock); #1;
    end
    frame_start = 1'b0;
    chk("finish", 32'({busy, done, plot}), 32'(3'b010));
    @(posedge clock); #1;
    chk("idle_after", 32'({busy, done, plot}), 32'(3'b000));
    chk("done_count", 32'(n_done - done0), 32'd1);
    chk("plots_player", 32'(seg[nseg - 2]), 32'(visible(px, 160) * visible(py, 120)));
    chk("plots_obstacle", 32'(seg[nseg - 1]), 32'(visible(ox, 160) * visible(oy, 120)));
    m_old   = '{px, py, ox, oy};
    m_valid = 1'b1;
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; clear_start = 1'b0;
    player_x = '0; player_y = '0; obstacle_x = '0; obstacle_y = '0;
    m_valid = 1'b0;
    m_old   = '{0, 0, 0, 0};
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outs", 32'({x, y, colour, plot, busy, done}), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // First frame: no erase phases.
    run_frame(20, 60, 144, 104, -1);
    // Second frame: erases at previous positions, then draws.
    run_frame(20, 58, 142, 104, -1);
    chk("old_px_model", 32'(exp_q.size()), 32'd1024);
    // Right-edge clipping: half-visible, then fully off-screen.
    run_frame(20, 58, 152, 104, -1);
    run_frame(20, 58, 160, 104, -1);
    // Bottom-edge clipping of the player.
    run_frame(20, 112, 100, 30, -1);

    for (int k = 0; k < 3; k++)
      run_frame(int'($urandom_range(0, 170)), int'($urandom_range(0, 130)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1);

    // Clear wins over a simultaneous frame request.
    begin
      int done0;
      done0 = n_done;
      @(negedge clock);
      clear_start = 1'b1; frame_start = 1'b1;
      @(posedge clock); #1;
      clear_start = 1'b0; frame_start = 1'b0;
      for (int yy = 0; yy < 120; yy++) begin
        for (int xx = 0; xx < 160; xx++) begin
          chk("clear_pix", 32'({busy, done, plot, x, y, colour}),
              32'({1'b1, 1'b0, 1'b1, 8'(xx), 7'(yy), 3'b000}));
          @(posedge clock); #1;
        end
      end
      chk("clear_finish", 32'({busy, done, plot}), 32'(3'b010));
      @(posedge clock); #1;
      chk("clear_done_count", 32'(n_done - done0), 32'd1);
      m_valid = 1'b0;
    end
    run_frame(40, 10, 60, 20, -1);

    // Asynchronous reset mid-frame.
    @(negedge clock);
    player_x = 8'd5; player_y = 8'd5; obstacle_x = 8'd70; obstacle_y = 8'd70;
    frame_start = 1'b1;
    @(posedge clock); #1;
    frame_start = 1'b0;
    repeat (299) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("reset_mid", 32'({x, y, colour, plot, busy, done}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    m_valid = 1'b0;
    // Frame after reset has no erases; a request while busy is ignored.
    run_frame(30, 40, 120, 90, 100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
